// File: rtl/regfile_if.sv
// Register-file access bus: write-back write port plus two decode read ports.
interface regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// 32 x 32 register file with r0 hardwired to zero, write-through bypass and a
// post-reset scrub that zero-fills r1..r31 so the storage itself needs no reset.
module regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus,
  output logic      init_busy_o
);

  typedef enum logic {StInit, StReady} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_ptr_q, scrub_ptr_d;
  // Bit n set: rn was written since reset, so the scrub must not clobber it.
  logic [NUM_REGS-1:0] wr_mask_q, wr_mask_d;
  logic [DATA_W-1:0]   mem [NUM_REGS];

  logic              ext_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign ext_wr      = bus.we && (bus.waddr != '0);
  assign init_busy_o = (state_q == StInit);

  // Next state: external writes own the array port; otherwise the scrub advances.
  always_comb begin
    state_d     = state_q;
    scrub_ptr_d = scrub_ptr_q;
    wr_mask_d   = wr_mask_q;
    mem_we      = ext_wr;
    mem_waddr   = bus.waddr;
    mem_wdata   = bus.wdata;
    if (state_q == StInit) begin
      if (ext_wr) begin
        wr_mask_d[bus.waddr] = 1'b1;
      end else begin
        if (!wr_mask_q[scrub_ptr_q]) begin
          mem_we    = 1'b1;
          mem_waddr = scrub_ptr_q;
          mem_wdata = '0;
        end
        scrub_ptr_d = scrub_ptr_q + 1'b1;
        if (scrub_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = StReady;
        end
      end
    end
  end

  // Control state with asynchronous reset; restarting the scrub from r1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      scrub_ptr_q <= ADDR_W'(1);
      wr_mask_q   <= '0;
    end else begin
      state_q     <= state_d;
      scrub_ptr_q <= scrub_ptr_d;
      wr_mask_q   <= wr_mask_d;
    end
  end

  // Storage array: no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read port 1: zero guards, bypass, then mask unscrubbed entries during init.
  always_comb begin
    bus.rdata1 = '0;
    if (rst || (bus.raddr1 == '0) || !bus.re1) begin
      bus.rdata1 = '0;
    end else if (bus.we && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
    end else if ((state_q == StInit) && (bus.raddr1 >= scrub_ptr_q) &&
                 !wr_mask_q[bus.raddr1]) begin
      bus.rdata1 = '0;
    end else begin
      bus.rdata1 = mem[bus.raddr1];
    end
  end

  // Read port 2: identical rules, independent of port 1.
  always_comb begin
    bus.rdata2 = '0;
    if (rst || (bus.raddr2 == '0) || !bus.re2) begin
      bus.rdata2 = '0;
    end else if (bus.we && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
    end else if ((state_q == StInit) && (bus.raddr2 >= scrub_ptr_q) &&
                 !wr_mask_q[bus.raddr2]) begin
      bus.rdata2 = '0;
    end else begin
      bus.rdata2 = mem[bus.raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: fixed vector table, hand-written scrub sequences and
// randomized traffic against an architectural register model.
module tb_regfile;

  logic clk;
  logic rst;
  logic init_busy;

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .init_busy_o (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_seen = 0;

  // Architectural view: every register reads 0 after reset until written;
  // the scrub lasts 31 idle-port cycles, stretched by each external write.
  logic [31:0] m_regs [32];
  int          m_busy_left;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        r1;
    logic [4:0]  a1;
    logic        r2;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
    if (rst || a == 5'd0 || !en) return 32'd0;
    if (bus.we && bus.waddr == a) return bus.wdata;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy_left = 31;
  endtask

  // Called at a negedge; holds rst for n cycles and returns at a negedge with rst low.
  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'd0;
    bus.re1 = 1'b1; bus.raddr1 = 5'($urandom_range(1, 31));
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    #1;
    chk("rst_rd1", bus.rdata1, 32'd0);
    chk("rst_rd2", bus.rdata2, 32'd0);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    m_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  // One cycle from a negedge: drive, check combinational outputs, clock, update model.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic r1, input logic [4:0] a1,
                     input logic r2, input logic [4:0] a2,
                     input logic use_exp, input logic [31:0] e1, input logic [31:0] e2,
                     input string tag);
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.re1 = r1; bus.raddr1 = a1; bus.re2 = r2; bus.raddr2 = a2;
    #1;
    chk({tag, "_rd1"}, bus.rdata1, use_exp ? e1 : m_read(r1, a1));
    chk({tag, "_rd2"}, bus.rdata2, use_exp ? e2 : m_read(r2, a2));
    chk({tag, "_busy"}, {31'd0, init_busy}, (m_busy_left > 0) ? 32'd1 : 32'd0);
    if (init_busy === 1'b1) busy_seen++;
    @(posedge clk);
    if (we && wa != 5'd0) m_regs[wa] = wd;
    if (m_busy_left > 0 && !(we && wa != 5'd0)) m_busy_left--;
    @(negedge clk);
  endtask

  task automatic cyc_m(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2, input string tag);
    cyc(we, wa, wd, r1, a1, r2, a2, 1'b0, 32'd0, 32'd0, tag);
  endtask

  initial begin
    int c;
    logic        rwe;
    logic [4:0]  rwa;
    logic [4:0]  ra1;

    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
    m_reset();
    @(negedge clk);

    // Reset to ready: 31 busy cycles, r5 reads 0 throughout and afterwards.
    do_reset(3);
    busy_seen = 0;
    c = 0;
    do begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 32'd0, 32'd0, "init");
      c++;
    end while (init_busy === 1'b1 && c < 100);
    chk("init_busy_len", 32'(busy_seen), 32'd31);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 32'd0, 32'd0, "ready_r5");

    // Fixed vectors in READY.
    vecs[0] = '{1'b1, 5'd7,  32'h1234_5678, 1'b1, 5'd5,  1'b0, 5'd0,  32'h0,         32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b0, 5'd7,  32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 5'd9,  32'hDEAD_BEEF, 1'b1, 5'd9,  1'b1, 5'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd9,  32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd9,  32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 5'd7,  32'h0000_0001, 1'b1, 5'd7,  1'b1, 5'd31, 32'h1,         32'h0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd7,  32'h1,         32'h1};
    vecs[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd30, 1'b1, 5'd31, 32'h0,         32'hA5A5_A5A5};
    vecs[8] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd31, 1'b1, 5'd31, 32'h0,         32'hA5A5_A5A5};
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].a1, vecs[i].r2, vecs[i].a2,
          1'b1, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
    end

    // Write to r0 during scrub: ignored, scrub length unchanged.
    do_reset(1);
    busy_seen = 0;
    c = 0;
    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'd0, 32'd0, "zero");
    while (init_busy === 1'b1 && c < 100) begin
      cyc_m(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd1, "zero_idle");
      c++;
    end
    chk("zero_busy_len", 32'(busy_seen), 32'd31);

    // Writes during scrub: r20 at cycle 2, r2 at cycle 3; scrub ends at cycle 33.
    do_reset(2);
    busy_seen = 0;
    c = 1;
    do begin
      if (c == 2)      cyc_m(1'b1, 5'd20, 32'hAAAA_0001, 1'b1, 5'd20, 1'b1, 5'd2, "wscrub");
      else if (c == 3) cyc_m(1'b1, 5'd2,  32'h0000_0005, 1'b1, 5'd20, 1'b1, 5'd2, "wscrub");
      else             cyc_m(1'b0, 5'd0,  32'd0,         1'b1, 5'd20, 1'b1, 5'd2, "wscrub");
      c++;
    end while (init_busy === 1'b1 && c < 100);
    chk("wscrub_busy_len", 32'(busy_seen), 32'd33);
    chk("wscrub_r20", m_regs[20], 32'hAAAA_0001);
    for (int a = 0; a < 32; a++) begin
      cyc_m(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 1'b1, 5'(31 - a), "sweep");
    end

    // Reset mid-scrub after r3 was written: r3 reads 0, scrub restarts at full length.
    do_reset(1);
    cyc_m(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 1'b0, 5'd0, "mid_w3");
    for (int i = 2; i < 15; i++) cyc_m(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd4, "mid_run");
    chk("mid_r3_before", m_regs[3], 32'h0000_0033);
    do_reset(1);
    busy_seen = 0;
    c = 0;
    do begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 32'd0, 32'd0, "mid_after");
      c++;
    end while (init_busy === 1'b1 && c < 100);
    chk("mid_busy_len", 32'(busy_seen), 32'd31);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        rwe = ($urandom_range(0, 2) == 0);
        rwa = 5'($urandom_range(0, 31));
        ra1 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
        cyc_m(rwe, rwa, $urandom, 1'($urandom_range(0, 3) != 0), ra1,
              1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
